// File: rtl/timer_match_sequencer.sv
// -----------------------------------------------------------------------------
// timer_match_sequencer
//
// Shares one free-running timebase among NUM_CH compare channels. Owns the
// timer, the period register and the per-channel match registers, and runs
// them either continuously or as a one-shot.
//
// Configuration writes arrive over a valid/ready handshake. While idle they
// land directly in the target register. While running they are parked in a
// single pending slot and take effect at the next period wrap (or on stop).
//
// Ports
//   newclk_k   in   clock, all state on rising edge
//   rstn       in   asynchronous active-low reset
//   start      in   level-sampled start request (ignored while running)
//   stop       in   level-sampled stop request (highest priority in RUN)
//   oneshot    in   mode, sampled on the start cycle: 1 = stop after first wrap
//   ch_en      in   per-channel trig enable, used live
//   cfg_valid  in   config write request
//   cfg_ready  out  config write accepted when cfg_valid & cfg_ready
//   cfg_addr   in   0..NUM_CH-1 = match[i], 4 = period, others discarded
//   cfg_data   in   write data
//   timer_out  out  current timer value
//   trig       out  1-cycle per-channel match pulses
//   wrap       out  1-cycle pulse on period wrap
//   done       out  1-cycle pulse on one-shot completion
//   busy       out  high while running
// -----------------------------------------------------------------------------
module timer_match_sequencer #(
   parameter int word_size = 8,
   parameter int NUM_CH    = 4
) (
   input  logic                 newclk_k,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 oneshot,
   input  logic [NUM_CH-1:0]    ch_en,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [2:0]           cfg_addr,
   input  logic [word_size-1:0] cfg_data,
   output logic [word_size-1:0] timer_out,
   output logic [NUM_CH-1:0]    trig,
   output logic                 wrap,
   output logic                 done,
   output logic                 busy
);

   localparam logic [2:0] PERIOD_ADDR = 3'd4;
   localparam logic [2:0] NUM_CH_A    = 3'(NUM_CH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [word_size-1:0]   timer_q, timer_d;
   logic [word_size-1:0]   period_q, period_d;
   logic [word_size-1:0]   match_q [NUM_CH];
   logic [word_size-1:0]   match_d [NUM_CH];
   logic                   mode_q, mode_d;
   logic                   pend_q, pend_d;
   logic [2:0]             pend_addr_q, pend_addr_d;
   logic [word_size-1:0]   pend_data_q, pend_data_d;
   logic [NUM_CH-1:0]      trig_q, trig_d;
   logic                   wrap_q, wrap_d;
   logic                   done_q, done_d;

   // single register-file write port shared by direct and committed writes
   logic                   wr_en;
   logic [2:0]             wr_addr;
   logic [word_size-1:0]   wr_data;

   logic                   accept;
   logic                   addr_ok;
   logic                   at_period;
   logic                   commit;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge newclk_k or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         period_q    <= '1;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            match_q[i] <= '0;
         end
         mode_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         trig_q      <= '0;
         wrap_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         period_q    <= period_d;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            match_q[i] <= match_d[i];
         end
         mode_q      <= mode_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         trig_q      <= trig_d;
         wrap_q      <= wrap_d;
         done_q      <= done_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath
   // -------------------------------------------------------------------------
   always_comb begin
      accept      = cfg_valid & ~pend_q;
      addr_ok     = (cfg_addr == PERIOD_ADDR) || (cfg_addr < NUM_CH_A);
      at_period   = (timer_q == period_q);

      state_d     = state_q;
      timer_d     = timer_q;
      mode_d      = mode_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      trig_d      = '0;
      wrap_d      = 1'b0;
      done_d      = 1'b0;
      commit      = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = cfg_addr;
      wr_data     = cfg_data;

      case (state_q)
         IDLE: begin
            // A write parked on the final edge of a run drains here so the
            // slot never stays occupied while idle.
            if (pend_q) begin
               commit = 1'b1;
            end else if (accept && addr_ok) begin
               wr_en = 1'b1;
            end
            if (start && !stop) begin
               state_d = RUN;
               mode_d  = oneshot;
               timer_d = '0;
            end
         end

         RUN: begin
            if (stop) begin
               state_d = IDLE;
               timer_d = '0;
               commit  = pend_q;
            end else begin
               for (int unsigned i = 0; i < NUM_CH; i++) begin
                  trig_d[i] = ch_en[i] & (timer_q == match_q[i]);
               end
               if (at_period) begin
                  timer_d = '0;
                  wrap_d  = 1'b1;
                  commit  = pend_q;
                  if (mode_q) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            // Capture only happens with an empty slot, so it never collides
            // with a commit on the same edge; a write accepted on a wrap edge
            // therefore waits for the following wrap.
            if (accept && addr_ok) begin
               pend_d      = 1'b1;
               pend_addr_d = cfg_addr;
               pend_data_d = cfg_data;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (commit) begin
         wr_en   = 1'b1;
         wr_addr = pend_addr_q;
         wr_data = pend_data_q;
         pend_d  = 1'b0;
      end

      period_d = period_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         match_d[i] = match_q[i];
      end
      if (wr_en) begin
         if (wr_addr == PERIOD_ADDR) begin
            period_d = wr_data;
         end
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (wr_addr == 3'(i)) begin
               match_d[i] = wr_data;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      busy      = (state_q == RUN);
      cfg_ready = ~pend_q;
      timer_out = timer_q;
      trig      = trig_q;
      wrap      = wrap_q;
      done      = done_q;
   end

endmodule

// File: tb/tb_timer_match_sequencer.sv
// -----------------------------------------------------------------------------
// tb_timer_match_sequencer
//
// Directed bench for timer_match_sequencer. A rule-level model tracks the
// expected outputs every cycle; literal expectations at key points pin the
// model against hand-worked values.
// -----------------------------------------------------------------------------
module tb_timer_match_sequencer;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start, stop, oneshot;
   logic [3:0] ch_en;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_data;
   logic [7:0] timer_out;
   logic [3:0] trig;
   logic       wrap, done, busy;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   timer_match_sequencer #(
      .word_size (8),
      .NUM_CH    (4)
   ) dut (
      .newclk_k  (clk),
      .rstn      (rstn),
      .start     (start),
      .stop      (stop),
      .oneshot   (oneshot),
      .ch_en     (ch_en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .timer_out (timer_out),
      .trig      (trig),
      .wrap      (wrap),
      .done      (done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Model: running flag, timer, registers, one pending slot
   // ---------------------------------------------------------------------------
   bit         m_run   = 1'b0;
   bit         m_one   = 1'b0;
   logic [7:0] m_timer = '0;
   logic [7:0] m_period = 8'hFF;
   logic [7:0] m_match [4] = '{default: 8'h00};
   bit         m_pend  = 1'b0;
   logic [2:0] m_paddr = '0;
   logic [7:0] m_pdata = '0;
   logic [3:0] m_trig  = '0;
   bit         m_wrap  = 1'b0;
   bit         m_done  = 1'b0;

   task automatic apply(input logic [2:0] a, input logic [7:0] d);
      if (a == 3'd4) m_period = d;
      else if (a < 3'd4) m_match[a[1:0]] = d;
   endtask

   always @(posedge clk or negedge rstn) begin : model
      bit take;
      if (!rstn) begin
         m_run = 1'b0; m_one = 1'b0; m_timer = '0; m_period = 8'hFF;
         for (int i = 0; i < 4; i++) m_match[i] = '0;
         m_pend = 1'b0; m_trig = '0; m_wrap = 1'b0; m_done = 1'b0;
      end else begin
         take = cfg_valid && !m_pend && (cfg_addr <= 3'd4);
         m_trig = '0; m_wrap = 1'b0; m_done = 1'b0;
         if (!m_run) begin
            if (m_pend) begin apply(m_paddr, m_pdata); m_pend = 1'b0; end
            else if (take) apply(cfg_addr, cfg_data);
            if (start && !stop) begin m_run = 1'b1; m_one = oneshot; m_timer = '0; end
         end else begin
            if (stop) begin
               if (m_pend) begin apply(m_paddr, m_pdata); m_pend = 1'b0; end
               m_run = 1'b0; m_timer = '0;
            end else begin
               for (int i = 0; i < 4; i++)
                  m_trig[i] = ch_en[i] && (m_timer == m_match[i]);
               if (m_timer == m_period) begin
                  if (m_pend) begin apply(m_paddr, m_pdata); m_pend = 1'b0; end
                  m_timer = '0; m_wrap = 1'b1;
                  if (m_one) begin m_run = 1'b0; m_done = 1'b1; end
               end else begin
                  m_timer = m_timer + 8'd1;
               end
            end
            if (take) begin m_pend = 1'b1; m_paddr = cfg_addr; m_pdata = cfg_data; end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("timer_out", timer_out, m_timer);
         chk("trig", trig, m_trig);
         chk("wrap", wrap, m_wrap);
         chk("done", done, m_done);
         chk("busy", busy, m_run);
         chk("cfg_ready", cfg_ready, !m_pend);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
      step();
      cfg_valid = 1'b0;
   endtask

   int exp_t1 [13] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0};
   int exp_t2 [7]  = '{0, 1, 2, 3, 0, 0, 0};
   int exp_t4 [4]  = '{0, 1, 2, 0};

   initial begin
      rstn = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0; ch_en = '0;
      cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      check_en = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_timer", timer_out, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_trig", trig, 0);
      step();

      // continuous run, period 5
      wr(3'd4, 8'd5); wr(3'd0, 8'd2); wr(3'd1, 8'd5);
      ch_en = 4'b0011; oneshot = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         chk("t1_timer", timer_out, exp_t1[k]);
         chk("t1_trig", trig, (k == 3 || k == 9) ? 1 : ((k == 6 || k == 12) ? 2 : 0));
         chk("t1_wrap", wrap, (k == 6 || k == 12) ? 1 : 0);
      end
      step(); stop = 1'b1; step(); stop = 1'b0;

      // one-shot, period 3
      wr(3'd4, 8'd3);
      oneshot = 1'b1; start = 1'b1;
      step();
      start = 1'b0; oneshot = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         chk("t2_timer", timer_out, exp_t2[k]);
         chk("t2_done", done, (k == 4) ? 1 : 0);
         chk("t2_wrap", wrap, (k == 4) ? 1 : 0);
         chk("t2_busy", busy, (k < 4) ? 1 : 0);
         chk("t2_trig", trig, (k == 3) ? 1 : 0);
      end
      step();

      // shadowed match write, period 7
      wr(3'd4, 8'd7);
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd6;
      step();
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("t3_ready_low", cfg_ready, 0);
      chk("t3_old_match", trig, 1);
      repeat (5) @(negedge clk);
      chk("t3_ready_back", cfg_ready, 1);
      chk("t3_wrap", wrap, 1);
      repeat (3) @(negedge clk);
      chk("t3_no_old", trig, 0);
      repeat (4) @(negedge clk);
      chk("t3_new_match", trig, 1);
      step();

      // stop with pending period write
      cfg_valid = 1'b1; cfg_addr = 3'd4; cfg_data = 8'd2;
      step();
      cfg_valid = 1'b0;
      step(); step(); step();
      chk("t4_timer4", timer_out, 4);
      chk("t4_pending", cfg_ready, 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_timer0", timer_out, 0);
      chk("t4_nowrap", wrap, 0);
      chk("t4_nodone", done, 0);
      chk("t4_ready", cfg_ready, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_timer", timer_out, exp_t4[k]);
         chk("t4_wrap", wrap, (k == 3) ? 1 : 0);
      end
      step(); stop = 1'b1; step(); stop = 1'b0;

      // period 0, continuous
      wr(3'd4, 8'd0); wr(3'd0, 8'd0);
      ch_en = 4'b0001; start = 1'b1;
      step();
      start = 1'b0;
      cfg_valid = 1'b1; cfg_addr = 3'd7; cfg_data = 8'd9;
      step();
      cfg_valid = 1'b0;
      chk("t5_ignored", cfg_ready, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t5_wrap", wrap, 1);
         chk("t5_trig", trig, 1);
      end
      step(); stop = 1'b1; step(); stop = 1'b0;
      chk("t5_wrap_off", wrap, 0);
      chk("t5_trig_off", trig, 0);
      chk("t5_busy_off", busy, 0);

      // asynchronous reset mid-run
      wr(3'd4, 8'd10);
      ch_en = 4'b0011; start = 1'b1;
      step();
      start = 1'b0;
      cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_data = 8'd7;
      step();
      cfg_valid = 1'b0;
      step(); step();
      chk("t6_timer3", timer_out, 3);
      #1 rstn = 1'b0;
      #1;
      chk("t6_timer", timer_out, 0);
      chk("t6_busy", busy, 0);
      chk("t6_ready", cfg_ready, 1);
      chk("t6_trig", trig, 0);
      chk("t6_wrap", wrap, 0);
      chk("t6_done", done, 0);
      step();
      rstn = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_match_reset", trig, 3);
      repeat (255) @(negedge clk);
      chk("t6_period_ff", wrap, 1);
      chk("t6_period_ff_timer", timer_out, 0);
      step(); stop = 1'b1; step(); stop = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
